// File: rtl/osd_nasti_lite_pkg.sv
// Shared definitions for the NASTI-lite width/ID adapter: response codes,
// adapter FSM states and the byte-lane extraction helper.
package osd_nasti_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest upstream data bus lane_byte can slice; callers zero-extend into it.
    localparam int unsigned LANE_MAX_DATA_W = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StBOut,
        StRdReq,
        StRdResp,
        StROut
    } state_e;

    function automatic logic [7:0] lane_byte(input logic [LANE_MAX_DATA_W-1:0] data,
                                             input int unsigned                lane);
        return data[8*lane +: 8];
    endfunction

endpackage

// File: rtl/osd_nasti_lite_downsizer.sv
// Single-slot NASTI-lite adapter: one wide single-beat upstream transaction is turned into
// one 8-bit downstream access, and the narrow response is returned with the upstream ID.
module osd_nasti_lite_downsizer
    import osd_nasti_lite_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned OUT_ADDR_WIDTH = 3,
    parameter int unsigned ADDR_SHIFT     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [ID_WIDTH-1:0]       s_aw_id_i,
    input  logic [ADDR_WIDTH-1:0]     s_aw_addr_i,
    input  logic                      s_aw_valid_i,
    output logic                      s_aw_ready_o,

    input  logic [DATA_WIDTH-1:0]     s_w_data_i,
    input  logic [DATA_WIDTH/8-1:0]   s_w_strb_i,
    input  logic                      s_w_valid_i,
    output logic                      s_w_ready_o,

    output logic [ID_WIDTH-1:0]       s_b_id_o,
    output logic [1:0]                s_b_resp_o,
    output logic                      s_b_valid_o,
    input  logic                      s_b_ready_i,

    input  logic [ID_WIDTH-1:0]       s_ar_id_i,
    input  logic [ADDR_WIDTH-1:0]     s_ar_addr_i,
    input  logic                      s_ar_valid_i,
    output logic                      s_ar_ready_o,

    output logic [ID_WIDTH-1:0]       s_r_id_o,
    output logic [DATA_WIDTH-1:0]     s_r_data_o,
    output logic [1:0]                s_r_resp_o,
    output logic                      s_r_last_o,
    output logic                      s_r_valid_o,
    input  logic                      s_r_ready_i,

    output logic [OUT_ADDR_WIDTH-1:0] m_aw_addr_o,
    output logic                      m_aw_valid_o,
    input  logic                      m_aw_ready_i,

    output logic [7:0]                m_w_data_o,
    output logic                      m_w_valid_o,
    input  logic                      m_w_ready_i,

    input  logic [1:0]                m_b_resp_i,
    input  logic                      m_b_valid_i,
    output logic                      m_b_ready_o,

    output logic [OUT_ADDR_WIDTH-1:0] m_ar_addr_o,
    output logic                      m_ar_valid_o,
    input  logic                      m_ar_ready_i,

    input  logic [7:0]                m_r_data_i,
    input  logic [1:0]                m_r_resp_i,
    input  logic                      m_r_valid_i,
    output logic                      m_r_ready_o
);

    localparam int unsigned LANE_BITS = $clog2(DATA_WIDTH / 8);
    // Keep a 1-bit lane index legal for an 8-bit upstream bus; the mask forces it to 0.
    localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;

    state_e                    state_q;
    logic                      last_was_write_q;
    logic [ID_WIDTH-1:0]       s_b_id_q;
    logic [1:0]                s_b_resp_q;
    logic                      s_b_valid_q;
    logic [ID_WIDTH-1:0]       s_r_id_q;
    logic [DATA_WIDTH-1:0]     s_r_data_q;
    logic [1:0]                s_r_resp_q;
    logic                      s_r_valid_q;
    logic [OUT_ADDR_WIDTH-1:0] m_aw_addr_q;
    logic                      m_aw_valid_q;
    logic [7:0]                m_w_data_q;
    logic                      m_w_valid_q;
    logic                      m_b_ready_q;
    logic [OUT_ADDR_WIDTH-1:0] m_ar_addr_q;
    logic                      m_ar_valid_q;
    logic                      m_r_ready_q;

    logic              idle;
    logic              wr_cand;
    logic              rd_cand;
    logic              pick_wr;
    logic              wr_accept;
    logic              rd_accept;
    logic [LANE_W-1:0] wr_lane;
    logic [7:0]        wr_byte;
    logic              wr_strb_bit;
    logic              aw_pend;
    logic              w_pend;
    logic              unused_inputs;

    assign idle    = (state_q == StIdle);
    assign wr_cand = s_aw_valid_i & s_w_valid_i;
    assign rd_cand = s_ar_valid_i;
    // Round-robin only matters when both sides are waiting.
    assign pick_wr   = wr_cand & (~rd_cand | ~last_was_write_q);
    assign wr_accept = idle & pick_wr;
    assign rd_accept = idle & rd_cand & ~pick_wr;

    assign s_aw_ready_o = wr_accept;
    assign s_w_ready_o  = wr_accept;
    assign s_ar_ready_o = rd_accept;

    assign wr_lane     = s_aw_addr_i[LANE_W-1:0] & LANE_W'(DATA_WIDTH / 8 - 1);
    assign wr_byte     = lane_byte(LANE_MAX_DATA_W'(s_w_data_i),
                                   {{(32 - LANE_W){1'b0}}, wr_lane});
    assign wr_strb_bit = s_w_strb_i[wr_lane];

    assign aw_pend = m_aw_valid_q & ~m_aw_ready_i;
    assign w_pend  = m_w_valid_q & ~m_w_ready_i;

    assign unused_inputs = ^{s_aw_addr_i, s_ar_addr_i, s_w_strb_i, s_w_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            last_was_write_q <= 1'b0;
            s_b_id_q         <= '0;
            s_b_resp_q       <= RESP_OKAY;
            s_b_valid_q      <= 1'b0;
            s_r_id_q         <= '0;
            s_r_data_q       <= '0;
            s_r_resp_q       <= RESP_OKAY;
            s_r_valid_q      <= 1'b0;
            m_aw_addr_q      <= '0;
            m_aw_valid_q     <= 1'b0;
            m_w_data_q       <= '0;
            m_w_valid_q      <= 1'b0;
            m_b_ready_q      <= 1'b0;
            m_ar_addr_q      <= '0;
            m_ar_valid_q     <= 1'b0;
            m_r_ready_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_accept) begin
                        last_was_write_q <= 1'b1;
                        s_b_id_q         <= s_aw_id_i;
                        m_aw_addr_q      <= s_aw_addr_i[ADDR_SHIFT +: OUT_ADDR_WIDTH];
                        m_w_data_q       <= wr_byte;
                        if (wr_strb_bit) begin
                            m_aw_valid_q <= 1'b1;
                            m_w_valid_q  <= 1'b1;
                            state_q      <= StWrReq;
                        end else begin
                            // Masked byte: answer locally without touching the slave.
                            s_b_resp_q  <= RESP_OKAY;
                            s_b_valid_q <= 1'b1;
                            state_q     <= StBOut;
                        end
                    end else if (rd_accept) begin
                        last_was_write_q <= 1'b0;
                        s_r_id_q         <= s_ar_id_i;
                        m_ar_addr_q      <= s_ar_addr_i[ADDR_SHIFT +: OUT_ADDR_WIDTH];
                        m_ar_valid_q     <= 1'b1;
                        state_q          <= StRdReq;
                    end
                end
                StWrReq: begin
                    m_aw_valid_q <= aw_pend;
                    m_w_valid_q  <= w_pend;
                    if (!aw_pend && !w_pend) begin
                        m_b_ready_q <= 1'b1;
                        state_q     <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (m_b_valid_i) begin
                        m_b_ready_q <= 1'b0;
                        s_b_resp_q  <= m_b_resp_i;
                        s_b_valid_q <= 1'b1;
                        state_q     <= StBOut;
                    end
                end
                StBOut: begin
                    if (s_b_ready_i) begin
                        s_b_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StRdReq: begin
                    if (m_ar_ready_i) begin
                        m_ar_valid_q <= 1'b0;
                        m_r_ready_q  <= 1'b1;
                        state_q      <= StRdResp;
                    end
                end
                StRdResp: begin
                    if (m_r_valid_i) begin
                        m_r_ready_q <= 1'b0;
                        s_r_data_q  <= {(DATA_WIDTH / 8){m_r_data_i}};
                        s_r_resp_q  <= m_r_resp_i;
                        s_r_valid_q <= 1'b1;
                        state_q     <= StROut;
                    end
                end
                StROut: begin
                    if (s_r_ready_i) begin
                        s_r_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_b_id_o     = s_b_id_q;
    assign s_b_resp_o   = s_b_resp_q;
    assign s_b_valid_o  = s_b_valid_q;
    assign s_r_id_o     = s_r_id_q;
    assign s_r_data_o   = s_r_data_q;
    assign s_r_resp_o   = s_r_resp_q;
    assign s_r_last_o   = 1'b1;
    assign s_r_valid_o  = s_r_valid_q;
    assign m_aw_addr_o  = m_aw_addr_q;
    assign m_aw_valid_o = m_aw_valid_q;
    assign m_w_data_o   = m_w_data_q;
    assign m_w_valid_o  = m_w_valid_q;
    assign m_b_ready_o  = m_b_ready_q;
    assign m_ar_addr_o  = m_ar_addr_q;
    assign m_ar_valid_o = m_ar_valid_q;
    assign m_r_ready_o  = m_r_ready_q;

endmodule

// File: tb/tb_osd_nasti_lite_downsizer.sv
// Bench for osd_nasti_lite_downsizer: directed scenarios plus random traffic against a
// transaction-level model of lane selection, arbitration order and response routing.
module tb_osd_nasti_lite_downsizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_aw_id, s_b_id, s_ar_id, s_r_id;
    logic [31:0] s_aw_addr, s_ar_addr;
    logic [63:0] s_w_data, s_r_data;
    logic [7:0]  s_w_strb;
    logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
    logic [1:0]  s_b_resp, s_r_resp;
    logic        s_b_valid, s_b_ready, s_ar_valid, s_ar_ready;
    logic        s_r_last, s_r_valid, s_r_ready;
    logic [2:0]  m_aw_addr, m_ar_addr;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
    logic [7:0]  m_w_data, m_r_data;
    logic [1:0]  m_b_resp, m_r_resp;
    logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

    always #5 clk = ~clk;

    osd_nasti_lite_downsizer #(
        .ID_WIDTH       (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (64),
        .OUT_ADDR_WIDTH (3),
        .ADDR_SHIFT     (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_aw_id_i    (s_aw_id),
        .s_aw_addr_i  (s_aw_addr),
        .s_aw_valid_i (s_aw_valid),
        .s_aw_ready_o (s_aw_ready),
        .s_w_data_i   (s_w_data),
        .s_w_strb_i   (s_w_strb),
        .s_w_valid_i  (s_w_valid),
        .s_w_ready_o  (s_w_ready),
        .s_b_id_o     (s_b_id),
        .s_b_resp_o   (s_b_resp),
        .s_b_valid_o  (s_b_valid),
        .s_b_ready_i  (s_b_ready),
        .s_ar_id_i    (s_ar_id),
        .s_ar_addr_i  (s_ar_addr),
        .s_ar_valid_i (s_ar_valid),
        .s_ar_ready_o (s_ar_ready),
        .s_r_id_o     (s_r_id),
        .s_r_data_o   (s_r_data),
        .s_r_resp_o   (s_r_resp),
        .s_r_last_o   (s_r_last),
        .s_r_valid_o  (s_r_valid),
        .s_r_ready_i  (s_r_ready),
        .m_aw_addr_o  (m_aw_addr),
        .m_aw_valid_o (m_aw_valid),
        .m_aw_ready_i (m_aw_ready),
        .m_w_data_o   (m_w_data),
        .m_w_valid_o  (m_w_valid),
        .m_w_ready_i  (m_w_ready),
        .m_b_resp_i   (m_b_resp),
        .m_b_valid_i  (m_b_valid),
        .m_b_ready_o  (m_b_ready),
        .m_ar_addr_o  (m_ar_addr),
        .m_ar_valid_o (m_ar_valid),
        .m_ar_ready_i (m_ar_ready),
        .m_r_data_i   (m_r_data),
        .m_r_resp_i   (m_r_resp),
        .m_r_valid_i  (m_r_valid),
        .m_r_ready_o  (m_r_ready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Downstream slave behaviour: wait cycles per channel (-1 = random 0..3).
    int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
    bit resp_rand;
    int rdata_fix;
    int aw_wt, w_wt, b_wt, ar_wt, r_wt;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_cnt, w_cnt, ar_cnt;
    logic [2:0] last_aw_addr, last_ar_addr;
    logic [7:0] last_w_data, last_r_data;
    logic [1:0] last_b_resp, last_r_resp;

    // Model of arbitration history: write wins a tie unless the previous accept was a write.
    bit model_last_wr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_wait(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    function automatic logic [1:0] pick_resp();
        return (resp_rand && ($urandom_range(0, 1) == 1)) ? 2'b10 : 2'b00;
    endfunction

    // Advance one clock; then act as the downstream slave for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (aw_hs) check_eq("aw_valid_drop", m_aw_valid, 1'b0);
        if (w_hs)  check_eq("w_valid_drop", m_w_valid, 1'b0);
        if (ar_hs) check_eq("ar_valid_drop", m_ar_valid, 1'b0);
        if (b_hs)  check_eq("b_ready_drop", m_b_ready, 1'b0);
        if (r_hs)  check_eq("r_ready_drop", m_r_ready, 1'b0);
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;

        if (m_aw_valid && aw_wt == 0) begin
            m_aw_ready = 1; aw_hs = 1; aw_cnt++; last_aw_addr = m_aw_addr;
        end else if (m_aw_valid) begin
            m_aw_ready = 0; aw_wt--;
        end else begin
            m_aw_ready = 0; aw_wt = next_wait(cfg_aw);
        end

        if (m_w_valid && w_wt == 0) begin
            m_w_ready = 1; w_hs = 1; w_cnt++; last_w_data = m_w_data;
        end else if (m_w_valid) begin
            m_w_ready = 0; w_wt--;
        end else begin
            m_w_ready = 0; w_wt = next_wait(cfg_w);
        end

        if (m_ar_valid && ar_wt == 0) begin
            m_ar_ready = 1; ar_hs = 1; ar_cnt++; last_ar_addr = m_ar_addr;
        end else if (m_ar_valid) begin
            m_ar_ready = 0; ar_wt--;
        end else begin
            m_ar_ready = 0; ar_wt = next_wait(cfg_ar);
        end

        if (m_b_ready && b_wt == 0) begin
            m_b_valid = 1; m_b_resp = pick_resp(); last_b_resp = m_b_resp; b_hs = 1;
        end else if (m_b_ready) begin
            m_b_valid = 0; b_wt--;
        end else begin
            m_b_valid = 0; b_wt = next_wait(cfg_b);
        end

        if (m_r_ready && r_wt == 0) begin
            m_r_valid = 1; m_r_resp = pick_resp();
            m_r_data = (rdata_fix < 0) ? 8'($urandom) : 8'(rdata_fix);
            last_r_data = m_r_data; last_r_resp = m_r_resp; r_hs = 1;
        end else if (m_r_ready) begin
            m_r_valid = 0; r_wt--;
        end else begin
            m_r_valid = 0; r_wt = next_wait(cfg_r);
        end
    endtask

    task automatic set_waits(input int v);
        cfg_aw = v; cfg_w = v; cfg_b = v; cfg_ar = v; cfg_r = v;
    endtask

    // Present a write and/or a read, predict the winner, finish it and check the response.
    task automatic run_txn(input bit pw, input bit pr,
                           input logic [3:0] wid, input logic [31:0] waddr,
                           input logic [63:0] wdata, input logic [7:0] wstrb,
                           input logic [3:0] rid, input logic [31:0] raddr, input int bdly);
        bit         win_w, zw, hit;
        int         t, n, aw0, w0, ar0, lane;
        logic [7:0] exp_byte;
        logic [1:0] exp_resp;
        logic [63:0] exp_rdata;
        zw = (cfg_aw == 0 && cfg_w == 0 && cfg_b == 0 && cfg_ar == 0 && cfg_r == 0);
        s_aw_valid = pw; s_w_valid = pw; s_aw_id = wid; s_aw_addr = waddr;
        s_w_data = wdata; s_w_strb = wstrb;
        s_ar_valid = pr; s_ar_id = rid; s_ar_addr = raddr;
        #1;
        win_w = pw && (!pr || !model_last_wr);
        check_eq("aw_ready", s_aw_ready, win_w);
        check_eq("w_ready", s_w_ready, win_w);
        check_eq("ar_ready", s_ar_ready, pr && !win_w);
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; t = cyc;
        tick();
        s_aw_valid = 0; s_w_valid = 0; s_ar_valid = 0;
        model_last_wr = win_w;
        n = 0;
        if (win_w) begin
            lane = int'(waddr[2:0]);
            exp_byte = wdata[8*lane +: 8];
            hit = wstrb[lane];
            while (!s_b_valid && n < 60) begin tick(); n++; end
            check_eq("b_valid_arrives", s_b_valid, 1'b1);
            if (zw) check_eq("b_latency", 64'(cyc - t), hit ? 64'd3 : 64'd1);
            check_eq("b_id", s_b_id, wid);
            if (hit) begin
                exp_resp = last_b_resp;
                check_eq("aw_count", 64'(aw_cnt), 64'(aw0 + 1));
                check_eq("w_count", 64'(w_cnt), 64'(w0 + 1));
                check_eq("m_aw_addr", last_aw_addr, waddr[2:0]);
                check_eq("m_w_data", last_w_data, exp_byte);
            end else begin
                exp_resp = 2'b00;
                check_eq("no_aw", 64'(aw_cnt), 64'(aw0));
                check_eq("no_w", 64'(w_cnt), 64'(w0));
            end
            check_eq("b_resp", s_b_resp, exp_resp);
            repeat (bdly) begin
                tick();
                check_eq("b_hold_valid", s_b_valid, 1'b1);
                check_eq("b_hold_id", s_b_id, wid);
                check_eq("b_hold_resp", s_b_resp, exp_resp);
            end
            s_b_ready = 1;
            tick();
            s_b_ready = 0;
            check_eq("b_valid_clear", s_b_valid, 1'b0);
        end else if (pr) begin
            while (!s_r_valid && n < 60) begin tick(); n++; end
            check_eq("r_valid_arrives", s_r_valid, 1'b1);
            if (zw) check_eq("r_latency", 64'(cyc - t), 64'd3);
            exp_rdata = {8{last_r_data}};
            exp_resp = last_r_resp;
            check_eq("ar_count", 64'(ar_cnt), 64'(ar0 + 1));
            check_eq("m_ar_addr", last_ar_addr, raddr[2:0]);
            check_eq("r_id", s_r_id, rid);
            check_eq("r_data", s_r_data, exp_rdata);
            check_eq("r_resp", s_r_resp, exp_resp);
            check_eq("r_last", s_r_last, 1'b1);
            repeat (bdly) begin
                tick();
                check_eq("r_hold_valid", s_r_valid, 1'b1);
                check_eq("r_hold_data", s_r_data, exp_rdata);
            end
            s_r_ready = 1;
            tick();
            s_r_ready = 0;
            check_eq("r_valid_clear", s_r_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1;
        s_aw_id = 0; s_aw_addr = 0; s_aw_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_valid = 0;
        s_b_ready = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_valid = 0; s_r_ready = 0;
        m_aw_ready = 0; m_w_ready = 0; m_b_resp = 0; m_b_valid = 0; m_ar_ready = 0;
        m_r_data = 0; m_r_resp = 0; m_r_valid = 0;
        aw_wt = 0; w_wt = 0; b_wt = 0; ar_wt = 0; r_wt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        last_aw_addr = 0; last_ar_addr = 0; last_w_data = 0; last_r_data = 0;
        last_b_resp = 0; last_r_resp = 0;
        set_waits(0); resp_rand = 0; rdata_fix = 8'h3C; model_last_wr = 0;
        repeat (2) tick();
        rst = 0;

        check_eq("rst_valids", {s_b_valid, s_r_valid, m_aw_valid, m_w_valid, m_ar_valid}, 5'b0);
        check_eq("rst_readies", {m_b_ready, m_r_ready, s_aw_ready, s_w_ready, s_ar_ready}, 5'b0);
        check_eq("rst_ids", {s_b_id, s_r_id}, 8'h00);
        check_eq("rst_r_data", s_r_data, 64'h0);
        check_eq("rst_m_fields", {m_aw_addr, m_ar_addr, m_w_data}, 14'h0);
        check_eq("rst_resps", {s_b_resp, s_r_resp}, 4'h0);

        // Directed zero-wait cases.
        run_txn(1, 0, 4'd5, 32'h0B, 64'h11223344_A5667788, 8'h08, 4'd0, 32'h0, 0);
        run_txn(1, 0, 4'd6, 32'h03, 64'hFFEEDDCC_BBAA9988, 8'h01, 4'd0, 32'h0, 0);
        run_txn(0, 1, 4'd0, 32'h0, 64'h0, 8'h00, 4'd2, 32'h05, 0);
        // Simultaneous requests alternate starting with the write.
        repeat (4) begin
            run_txn(1, 1, 4'd9, 32'h0E, 64'h0123456789ABCDEF, 8'hFF, 4'd4, 32'h01, 0);
        end

        // Address ready two cycles ahead of data ready, then a slow upstream B consumer.
        cfg_w = 2;
        run_txn(1, 0, 4'd7, 32'h12, 64'h55AA55AA_C3C3C3C3, 8'h04, 4'd0, 32'h0, 3);

        // Reset while the read response is being awaited.
        set_waits(0);
        cfg_r = 8;
        s_ar_valid = 1; s_ar_id = 4'd7; s_ar_addr = 32'h06;
        #1;
        check_eq("rst_txn_ar_ready", s_ar_ready, 1'b1);
        tick();
        s_ar_valid = 0;
        repeat (2) tick();
        check_eq("rst_txn_in_rd_resp", m_r_ready, 1'b1);
        rst = 1;
        tick();
        rst = 0;
        check_eq("rst_mid_valids", {s_b_valid, s_r_valid, m_aw_valid, m_w_valid, m_ar_valid},
                 5'b0);
        check_eq("rst_mid_readies", {m_b_ready, m_r_ready}, 2'b0);
        check_eq("rst_mid_r_id", s_r_id, 4'd0);
        model_last_wr = 0;
        cfg_r = 0;
        rdata_fix = 8'h96;
        run_txn(0, 1, 4'd0, 32'h0, 64'h0, 8'h00, 4'd3, 32'h1C, 0);

        // Random traffic with random slave waits and responses.
        set_waits(-1);
        resp_rand = 1;
        rdata_fix = -1;
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            run_txn(sel[0], sel[1], 4'($urandom), $urandom, {$urandom, $urandom},
                    8'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/osd_nasti_lite_downsizer.md
# osd_nasti_lite_downsizer

Single-slot NASTI-lite width/ID adapter between the 64-bit system interconnect and the 8-bit, 3-bit-address, ID-less slave port of the debug UART bridge. It accepts one upstream single-beat read or write, selects the addressed byte lane, and issues exactly one narrow transaction downstream. It returns the narrow response with the upstream ID restored and read data replicated across all lanes.

## Interface
Parameters:
- ID_WIDTH, 4, upstream AXI ID width.
- ADDR_WIDTH, 32, upstream address width.
- DATA_WIDTH, 64, upstream data width; power of two, at least 8.
- OUT_ADDR_WIDTH, 3, downstream address width.
- ADDR_SHIFT, 0, LSB of the downstream register index in the upstream address (use 2 for word-strided maps).

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- s_aw_id / s_aw_addr / s_aw_valid / s_aw_ready  in/in/in/out  ID_WIDTH/ADDR_WIDTH/1/1  upstream write address.
- s_w_data / s_w_strb / s_w_valid / s_w_ready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  upstream write data.
- s_b_id / s_b_resp / s_b_valid / s_b_ready  out/out/out/in  ID_WIDTH/2/1/1  upstream write response.
- s_ar_id / s_ar_addr / s_ar_valid / s_ar_ready  in/in/in/out  ID_WIDTH/ADDR_WIDTH/1/1  upstream read address.
- s_r_id / s_r_data / s_r_resp / s_r_last / s_r_valid / s_r_ready  out×5/in  ID_WIDTH/DATA_WIDTH/2/1/1/1  upstream read data; s_r_last is tied to 1.
- m_aw_addr, m_aw_valid, m_aw_ready, m_w_data[7:0], m_w_valid, m_w_ready, m_b_resp, m_b_valid, m_b_ready, m_ar_addr, m_ar_valid, m_ar_ready, m_r_data[7:0], m_r_resp, m_r_valid, m_r_ready: the downstream narrow port. Both address ports are OUT_ADDR_WIDTH wide.

## Operation
- Derived values: LANE_BITS = log2(DATA_WIDTH/8); lane = addr[LANE_BITS-1:0]; m_addr = addr[ADDR_SHIFT +: OUT_ADDR_WIDTH].
- States: IDLE, WR_REQ, WR_RESP, B_OUT, RD_REQ, RD_RESP, R_OUT. One transaction is outstanding at a time.
- IDLE, write candidate: requires s_aw_valid & s_w_valid together. Read candidate: s_ar_valid.
- Arbitration: if both candidates are present, use round-robin on a last_was_write flag. After reset, write wins.
- Write accept: s_aw_ready = s_w_ready = 1 in the same cycle. Capture id, m_addr, byte w_data[8*lane +: 8] and strobe bit w_strb[lane].
  - Strobe bit 0: go to B_OUT with resp OKAY and no downstream access.
  - Otherwise: go to WR_REQ.
- Read accept: assert s_ar_ready and capture id and m_addr, then go to RD_REQ.
- WR_REQ: m_aw_valid = m_w_valid = 1 and held until both readies have been seen. Readies may arrive in different cycles; each valid drops individually after its own handshake. Then go to WR_RESP.
- WR_RESP: m_b_ready = 1. On m_b_valid, capture m_b_resp and go to B_OUT.
- RD_REQ: m_ar_valid = 1 until m_ar_ready, then go to RD_RESP.
- RD_RESP: m_r_ready = 1. On m_r_valid, capture {DATA_WIDTH/8{m_r_data}} and m_r_resp, then go to R_OUT.
- B_OUT / R_OUT: response valid is held with stable id, resp and data until the upstream ready; then go to IDLE.
- Other strobe bits and upper address bits are ignored.

## Timing
- Reset: state IDLE; every valid and ready output 0; s_b_id, s_r_id, s_r_data, m_*_addr and m_w_data 0; resp outputs 00; last_was_write 0.
- Upstream accept readies are combinational from IDLE and the upstream valids. All other outputs are registered.
- Minimum latency, from upstream accept (cycle t) to the upstream response valid, with zero-wait downstream:
  - t+1: downstream request.
  - t+2: the earliest cycle downstream can respond.
  - t+3: upstream response valid.
  - Downstream wait states add cycle-for-cycle.
- Write with strobe lane 0: s_b_valid at t+1.
- No new upstream accept until the response handshake completes. Back-to-back throughput is therefore at most 1 transaction per 4 cycles.
- Reset asserted in any state: next cycle is IDLE with all valids low. An in-flight downstream transaction is abandoned, and the downstream block shares rst.

## Structure
- Shared package osd_nasti_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - The state enum.
  - A function lane_byte(data, lane).
- No sub-module; a single FSM with capture registers.

## Test plan
- Write id=5, addr=0x0B, strb=0x08, data byte3=0xA5 (ADDR_SHIFT=0) -> downstream m_aw_addr=3, m_w_data=0xA5; s_b_id=5, resp 00, valid at t+3 with zero-wait.
- Read id=2, addr=0x05, downstream m_r_data=0x3C -> m_ar_addr=5; s_r_data=0x3C3C3C3C3C3C3C3C, s_r_id=2, s_r_last=1.
- Write with strb=0x01 and addr lane 3 -> no downstream valid; s_b_valid at t+1, resp 00.
- Write and read valid simultaneously, twice -> order is write, read, write, read.
- Stalls: m_aw_ready two cycles before m_w_ready, then s_b_ready low for 3 cycles -> each downstream valid drops on its own handshake; s_b_valid, id and resp stay stable until s_b_ready.
- rst pulsed during RD_RESP -> next cycle all valids 0, state IDLE; the next read completes normally.
